// File: rtl/e_mdu_if.sv
// e_mdu_if: operand/result bundle between the E stage and the multiply/divide unit.
// master drives the instruction side; slave is the MDU itself.
interface e_mdu_if;
    logic        en;
    logic [3:0]  mdOp;
    logic [31:0] srcA;
    logic [31:0] srcB;
    logic        start;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output en, mdOp, srcA, srcB,
        input  start, busy, hi, lo
    );

    modport slave (
        input  en, mdOp, srcA, srcB,
        output start, busy, hi, lo
    );
endinterface

// File: rtl/e_mdu.sv
// e_mdu: multi-cycle multiply/divide unit for the E stage, owning HI/LO.
// The result is computed at the start edge and parked in pend_hi/pend_lo; the
// unit then holds busy for a fixed number of cycles before committing to HI/LO.
// Optional madd/maddu accumulate support is compiled in when MDU_MADD_EN is defined.
module e_mdu #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic     clk,
    input  logic     reset,
    e_mdu_if.slave   bus
);
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
`endif

    localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] pend_hi_q, pend_hi_d;
    logic [31:0] pend_lo_q, pend_lo_d;
    logic        pend_wr_q, pend_wr_d;

    logic        is_mul;
    logic        is_div;
    logic        start;
    logic        signed_div;
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [63:0] mul_res;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [31:0] div_b;
    logic [31:0] uq;
    logic [31:0] ur;
    logic [31:0] quot;
    logic [31:0] rem;

    // Decode which long-latency op (if any) is being presented and whether it may start.
    always_comb begin
        is_mul = (bus.mdOp == OP_MULT) || (bus.mdOp == OP_MULTU);
`ifdef MDU_MADD_EN
        is_mul = is_mul || (bus.mdOp == OP_MADD) || (bus.mdOp == OP_MADDU);
`endif
        is_div = (bus.mdOp == OP_DIV) || (bus.mdOp == OP_DIVU);
        start  = bus.en && (is_mul || is_div) && (state_q == IDLE);
    end

    // Product and sign-magnitude division; the divisor is forced non-zero so the divider never sees 0.
    always_comb begin
        prod_s  = {{32{bus.srcA[31]}}, bus.srcA} * {{32{bus.srcB[31]}}, bus.srcB};
        prod_u  = {32'b0, bus.srcA} * {32'b0, bus.srcB};
        mul_res = (bus.mdOp == OP_MULT) ? prod_s : prod_u;
`ifdef MDU_MADD_EN
        if (bus.mdOp == OP_MADD) begin
            mul_res = {hi_q, lo_q} + prod_s;
        end else if (bus.mdOp == OP_MADDU) begin
            mul_res = {hi_q, lo_q} + prod_u;
        end
`endif
        signed_div = (bus.mdOp == OP_DIV);
        abs_a = (signed_div && bus.srcA[31]) ? (32'd0 - bus.srcA) : bus.srcA;
        abs_b = (signed_div && bus.srcB[31]) ? (32'd0 - bus.srcB) : bus.srcB;
        div_b = (abs_b == 32'd0) ? 32'd1 : abs_b;
        uq    = abs_a / div_b;
        ur    = abs_a % div_b;
        quot  = (signed_div && (bus.srcA[31] ^ bus.srcB[31])) ? (32'd0 - uq) : uq;
        rem   = (signed_div && bus.srcA[31]) ? (32'd0 - ur) : ur;
    end

    // Next-state: launch an op from IDLE, count down in RUN, commit on the last busy cycle.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_wr_d = pend_wr_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    if (is_mul) begin
                        cnt_d     = MULT_N;
                        pend_hi_d = mul_res[63:32];
                        pend_lo_d = mul_res[31:0];
                        pend_wr_d = 1'b1;
                    end else begin
                        cnt_d     = DIV_N;
                        pend_hi_d = rem;
                        pend_lo_d = quot;
                        pend_wr_d = (bus.srcB != 32'd0);
                    end
                end else if (bus.en && bus.mdOp == OP_MTHI) begin
                    hi_d = bus.srcA;
                end else if (bus.en && bus.mdOp == OP_MTLO) begin
                    lo_d = bus.srcA;
                end
            end
            RUN: begin
                if (cnt_q > 4'd1) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                    if (pend_wr_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and HI/LO registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            pend_wr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_wr_q <= pend_wr_d;
        end
    end

    assign bus.start = start;
    assign bus.busy  = (state_q == RUN);
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
endmodule
